// File: rtl/fifo_stream_pkg.sv
// Register offsets and STATUS/CTRL bit positions for the FIFO stream slot.
package fifo_stream_pkg;

    localparam logic [2:0] OFF_STATUS = 3'd0;
    localparam logic [2:0] OFF_PUSH   = 3'd1;
    localparam logic [2:0] OFF_POP    = 3'd2;
    localparam logic [2:0] OFF_PEEK   = 3'd3;
    localparam logic [2:0] OFF_CTRL   = 3'd4;

    localparam int ST_FULL   = 31;
    localparam int ST_EMPTY  = 30;
    localparam int ST_AFULL  = 29;
    localparam int ST_OVF    = 28;
    localparam int ST_UDF    = 27;

    localparam int CTRL_IRQ_EN = 16;
    localparam int CTRL_FLUSH  = 30;
    localparam int CTRL_CLR    = 31;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO storage with wrapping pointers, occupancy count and full/empty.
module fifo_sync #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic                  i_flush,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_head,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign w_do_push = i_push & ~o_full  & ~i_flush;
    assign w_do_pop  = i_pop  & ~o_empty & ~i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;
    // count never exceeds DEPTH, so its MSB alone marks full
    assign o_full  = r_count[ADDR_WIDTH];
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/fifo_stream_core.sv
// Register-slot front end for fifo_sync: decode, sticky flags, CTRL and irq.
module fifo_stream_core
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        irq
);

    logic [2:0]            w_off;
    logic                  w_push_req;
    logic                  w_pop_req;
    logic                  w_ctrl_wr;
    logic                  w_flush;
    logic                  w_clr;
    logic [DATA_WIDTH-1:0] w_head;
    logic [ADDR_WIDTH:0]   w_count;
    logic [15:0]           w_count16;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_afull;
    logic                  w_unused;

    logic [15:0]           r_thr;
    logic                  r_irq_en;
    logic                  r_ovf;
    logic                  r_udf;
    logic                  r_irq;

    assign w_off      = addr[2:0];
    assign w_push_req = cs & write & (w_off == OFF_PUSH);
    assign w_pop_req  = cs & read  & (w_off == OFF_POP);
    assign w_ctrl_wr  = cs & write & (w_off == OFF_CTRL);
    assign w_flush    = w_ctrl_wr & wr_data[CTRL_FLUSH];
    assign w_clr      = w_ctrl_wr & wr_data[CTRL_CLR];
    assign w_unused   = &{1'b0, addr[4:3], wr_data[29:17]};

    fifo_sync #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_push_req),
        .i_pop   (w_pop_req),
        .i_flush (w_flush),
        .i_wdata (wr_data[DATA_WIDTH-1:0]),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_count16 = 16'(w_count);
    assign w_afull   = (r_thr != '0) && (w_count16 >= r_thr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_thr    <= '0;
            r_irq_en <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_thr    <= wr_data[15:0];
                r_irq_en <= wr_data[CTRL_IRQ_EN];
            end
            r_ovf <= (r_ovf & ~w_clr) | (w_push_req & w_full);
            r_udf <= (r_udf & ~w_clr) | (w_pop_req & w_empty);
            // irq follows the flag state one edge after it settles
            r_irq <= r_irq_en & (r_ovf | r_udf | w_afull);
        end
    end

    always_comb begin
        rd_data = '0;
        case (w_off)
            OFF_STATUS: begin
                rd_data[ST_FULL]  = w_full;
                rd_data[ST_EMPTY] = w_empty;
                rd_data[ST_AFULL] = w_afull;
                rd_data[ST_OVF]   = r_ovf;
                rd_data[ST_UDF]   = r_udf;
                rd_data[15:0]     = w_count16;
            end
            OFF_POP, OFF_PEEK: begin
                if (!w_empty) rd_data = 32'(w_head);
            end
            OFF_CTRL: begin
                rd_data[15:0]       = r_thr;
                rd_data[CTRL_IRQ_EN] = r_irq_en;
            end
            default: rd_data = '0;
        endcase
    end

    assign irq = r_irq;

endmodule

// File: tb/tb_fifo_stream_core.sv
// Randomized self-checking bench for fifo_stream_core against a queue-based model.
module tb_fifo_stream_core;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cs = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        irq;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    logic [7:0]  m_q[$];
    logic        m_ovf = 1'b0;
    logic        m_udf = 1'b0;
    logic [15:0] m_thr = '0;
    logic        m_en = 1'b0;

    always #5 clk = ~clk;

    fifo_stream_core #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic m_afull();
        return (m_thr != 0) && (m_q.size() >= int'(m_thr));
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'(m_q.size());
        s[31] = (m_q.size() == 16);
        s[30] = (m_q.size() == 0);
        s[29] = m_afull();
        s[28] = m_ovf;
        s[27] = m_udf;
        return s;
    endfunction

    task automatic access(input bit wr, input bit rd, input logic [2:0] off,
                          input logic [31:0] wd, output logic [31:0] rdv);
        @(negedge clk);
        cs = 1'b1; write = wr; read = rd; addr = {2'b00, off}; wr_data = wd;
        #1 rdv = rd_data;
        @(posedge clk);
        #1 cs = 1'b0; write = 1'b0; read = 1'b0; addr = '0;
    endtask

    task automatic push(input logic [7:0] d);
        logic [31:0] r;
        access(1'b1, 1'b0, 3'd1, {24'hDEAD00, d}, r);
        if (m_q.size() == 16) m_ovf = 1'b1;
        else m_q.push_back(d);
    endtask

    task automatic pop(input string tag);
        logic [31:0] r;
        logic [31:0] e;
        e = (m_q.size() == 0) ? 32'h0 : 32'(m_q[0]);
        access(1'b0, 1'b1, 3'd2, 32'h0, r);
        check(tag, r, e);
        if (m_q.size() == 0) m_udf = 1'b1;
        else void'(m_q.pop_front());
    endtask

    task automatic peek(input string tag);
        logic [31:0] r;
        access(1'b0, 1'b1, 3'd3, 32'h0, r);
        check(tag, r, (m_q.size() == 0) ? 32'h0 : 32'(m_q[0]));
    endtask

    task automatic ctrl_wr(input logic [31:0] v);
        logic [31:0] r;
        access(1'b1, 1'b0, 3'd4, v, r);
        m_thr = v[15:0];
        m_en  = v[16];
        if (v[30]) m_q.delete();
        if (v[31]) begin m_ovf = 1'b0; m_udf = 1'b0; end
    endtask

    task automatic chk_status(input string tag);
        @(negedge clk);
        addr = 5'd0;
        #1 check(tag, rd_data, m_status());
    endtask

    // one idle edge lets irq catch up with settled flags
    task automatic chk_irq(input string tag);
        @(posedge clk);
        #1 check(tag, 32'(irq), 32'(m_en && (m_ovf || m_udf || m_afull())));
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  d;

        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;

        chk_status("reset_status");
        check("reset_irq", 32'(irq), 32'h0);
        access(1'b0, 1'b1, 3'd4, 32'h0, r);
        check("reset_ctrl", r, 32'h0);
        access(1'b0, 1'b1, 3'd5, 32'h0, r);
        check("unmapped_read", r, 32'h0);

        for (int i = 1; i <= 16; i++) push(8'(i));
        chk_status("fill16_status");
        check("fill16_exact", rd_data, 32'h8000_0010);
        for (int i = 1; i <= 16; i++) begin
            check("pop_order_model", 32'(m_q[0]), 32'(i));
            pop("pop_order");
        end
        chk_status("drain16_status");

        for (int i = 0; i < 10; i++) push(8'($urandom));
        for (int i = 0; i < 10; i++) pop("wrap_pop10");
        for (int i = 0; i < 16; i++) push(8'($urandom));
        chk_status("wrap_full");
        for (int i = 0; i < 16; i++) pop("wrap_pop16");
        chk_status("wrap_empty");

        for (int i = 0; i < 16; i++) push(8'(i + 8'h30));
        push(8'hAA);
        chk_status("ovf_status");
        for (int i = 0; i < 16; i++) pop("ovf_pop");
        ctrl_wr(32'h8000_0000);
        chk_status("ovf_cleared");

        peek("peek_empty");
        chk_status("peek_empty_flags");

        ctrl_wr(32'h0001_0000);
        pop("udf_pop_zero");
        chk_status("udf_status");
        chk_irq("udf_irq_set");
        ctrl_wr(32'h8001_0000);
        chk_irq("udf_irq_clr");

        ctrl_wr(32'h0000_000C);
        for (int i = 0; i < 11; i++) push(8'($urandom));
        chk_status("thr_11");
        push(8'h5C);
        chk_status("thr_12");
        peek("thr_peek");
        ctrl_wr(32'h4000_000C);
        chk_status("thr_flush");

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin d = 8'($urandom); push(d); end
                4, 5, 6:    pop("rand_pop");
                7:          peek("rand_peek");
                8: begin
                    r = {$urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
                         13'h0, 1'($urandom), 16'($urandom_range(0, 17))};
                    ctrl_wr(r);
                end
                default: begin
                    access(1'b1, 1'b0, 3'(5 + $urandom_range(0, 2)), $urandom, r);
                end
            endcase
            chk_status("rand_status");
            chk_irq("rand_irq");
        end

        ctrl_wr(32'h4001_0003);
        for (int i = 0; i < 5; i++) push(8'(i));
        @(negedge clk);
        cs = 1'b1; write = 1'b1; addr = 5'd1; wr_data = 32'h77;
        #2 reset = 1'b0;
        #1 cs = 1'b0; write = 1'b0;
        m_q.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_thr = '0; m_en = 1'b0;
        @(posedge clk);
        #1 check("rst_irq", 32'(irq), 32'h0);
        addr = 5'd0;
        #1 check("rst_status", rd_data, 32'h4000_0000);
        @(negedge clk) reset = 1'b1;
        chk_status("rst_release_status");
        access(1'b0, 1'b1, 3'd4, 32'h0, r);
        check("rst_ctrl", r, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
